alu_mc: RTL

Parametrised multi-cycle ALU for the MIPS datapath, successor to the single-cycle `ALU`. It adds a start/busy/done handshake and iterative radix-2 multiply/divide that share one shift datapath. It supports signed and unsigned MULT/DIV, arithmetic right shift, and unsigned compare. It sits in the EX stage; the control FSM stalls on `alu_busy` and writes HI/LO when `alu_done` pulses.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 93 +++++++++
 rtl/alu_mc.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and width-generic constants for the
// multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_DIV   = 4'b1001;
  localparam logic [3:0] ALU_MULTU = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  // Most negative two's-complement value of the given width (width <= 64).
  function automatic logic [63:0] min_signed(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine: one shared accumulator/shift
// register, one bit per clock, WIDTH iterations, sign fix-up on the way out.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MIN      = WIDTH'(min_signed(WIDTH));
  localparam logic [SHW:0]     LAST_CNT = (SHW + 1)'(WIDTH);

  logic [2*WIDTH:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic [SHW:0]       cnt_reg;
  logic               div_reg, neg_hi_reg, neg_lo_reg, zero_div_reg, min_ovf_reg;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     upper, mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign neg_a = is_signed & a[WIDTH-1];
  assign neg_b = is_signed & b[WIDTH-1];
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  // Multiply adds into the upper half then shifts right; divide shifts the
  // {remainder, quotient} pair left and keeps the trial subtraction if it fits.
  assign upper   = acc_reg[2*WIDTH:WIDTH];
  assign mul_sum = upper + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign rem_sh  = acc_reg[2*WIDTH-1:WIDTH-1];
  assign trial   = rem_sh - {1'b0, opnd_reg};

  always_comb begin
    acc_next = acc_reg;
    if (!div_reg)
      acc_next = {1'b0, mul_sum, acc_reg[WIDTH-1:1]};
    else if (trial[WIDTH])
      acc_next = {rem_sh, acc_reg[WIDTH-2:0], 1'b0};
    else
      acc_next = {trial, acc_reg[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      opnd_reg     <= '0;
      cnt_reg      <= LAST_CNT;
      div_reg      <= 1'b0;
      neg_hi_reg   <= 1'b0;
      neg_lo_reg   <= 1'b0;
      zero_div_reg <= 1'b0;
      min_ovf_reg  <= 1'b0;
    end else if (start) begin
      acc_reg      <= {{(WIDTH+1){1'b0}}, (is_div ? mag_a : mag_b)};
      opnd_reg     <= is_div ? mag_b : mag_a;
      cnt_reg      <= '0;
      div_reg      <= is_div;
      neg_hi_reg   <= is_div ? neg_a : (neg_a ^ neg_b);
      neg_lo_reg   <= neg_a ^ neg_b;
      zero_div_reg <= is_div & (b == '0);
      min_ovf_reg  <= is_div & is_signed & (a == MIN) & (b == '1);
    end else if (cnt_reg != LAST_CNT) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign prod = neg_hi_reg ? -acc_reg[2*WIDTH-1:0] : acc_reg[2*WIDTH-1:0];
  assign quo  = acc_reg[WIDTH-1:0];
  assign rem  = acc_reg[2*WIDTH-1:WIDTH];

  assign last = (cnt_reg == LAST_CNT);
  assign hi   = div_reg ? (neg_hi_reg ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
  assign lo   = div_reg ? (zero_div_reg ? '1 : (neg_lo_reg ? -quo : quo))
                        : prod[WIDTH-1:0];
  assign ovf  = div_reg & (zero_div_reg | min_ovf_reg);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle ops complete in one edge, MULT/DIV
// run through the iterative engine behind a start/busy/done handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_srcA,
  input  logic [WIDTH-1:0] alu_srcB,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             alu_zero,
  output logic             alu_busy,
  output logic             alu_done
);

  state_t           state_reg;
  logic [WIDTH-1:0] result_reg, hi_reg, lo_reg;
  logic             ovf_reg, done_reg, busy_reg;

  logic [WIDTH-1:0] sum, diff, sc_result, md_hi, md_lo;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf, is_md, md_start, md_last, md_ovf;

  assign sum      = alu_srcA + alu_srcB;
  assign diff     = alu_srcA - alu_srcB;
  assign shamt    = alu_srcA[SHW-1:0];
  assign is_md    = (alu_control[3:2] == 2'b10);
  assign md_start = (state_reg == S_IDLE) & en & is_md;

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        sc_result = sum;
        sc_ovf    = (alu_srcA[WIDTH-1] == alu_srcB[WIDTH-1]) &&
                    (sum[WIDTH-1] != alu_srcA[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_result = diff;
        sc_ovf    = (alu_srcA[WIDTH-1] != alu_srcB[WIDTH-1]) &&
                    (diff[WIDTH-1] != alu_srcA[WIDTH-1]);
      end
      ALU_AND:  sc_result = alu_srcA & alu_srcB;
      ALU_OR:   sc_result = alu_srcA | alu_srcB;
      ALU_NOR:  sc_result = ~(alu_srcA | alu_srcB);
      ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(alu_srcA) < $signed(alu_srcB))};
      ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (alu_srcA < alu_srcB)};
      ALU_SLL:  sc_result = alu_srcB << shamt;
      ALU_SRL:  sc_result = alu_srcB >> shamt;
      ALU_SRA:  sc_result = $signed(alu_srcB) >>> shamt;
      default: begin
        sc_result = '0;
        sc_ovf    = 1'b0;
      end
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .is_div    (alu_control[0]),
    .is_signed (~alu_control[1]),
    .a         (alu_srcA),
    .b         (alu_srcB),
    .last      (md_last),
    .hi        (md_hi),
    .lo        (md_lo),
    .ovf       (md_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      result_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (en) begin
            if (is_md) begin
              busy_reg  <= 1'b1;
              state_reg <= alu_control[0] ? S_DIV : S_MUL;
            end else begin
              result_reg <= sc_result;
              ovf_reg    <= sc_ovf;
              done_reg   <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          // Engine has finished its WIDTH iterations: this edge finalizes.
          if (md_last) begin
            hi_reg    <= md_hi;
            lo_reg    <= md_lo;
            ovf_reg   <= md_ovf;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign alu_result = result_reg;
  assign hi         = hi_reg;
  assign lo         = lo_reg;
  assign overflow   = ovf_reg;
  assign alu_zero   = (result_reg == '0);
  assign alu_busy   = busy_reg;
  assign alu_done   = done_reg;

endmodule
